// File: rtl/game_pkg.sv
// +------------------------------------------------------------------+
// | game_pkg: shared game-logic types and constants                  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package game_pkg;

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    HIT      = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [15:0] BCD_MAX = 16'h9999;

endpackage

`default_nettype wire

// File: rtl/bcd_incrementer.sv
// +------------------------------------------------------------------+
// | bcd_incrementer: combinational 4-digit BCD +1 with carry-out     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module bcd_incrementer
  import game_pkg::*;
(
  input  logic [15:0] value,
  output logic [15:0] result,
  output logic        carry_out
);

  logic [4:0] carry;

  assign carry[0]  = 1'b1;
  assign carry_out = carry[4];

  generate
    for (genvar i = 0; i < 4; i++) begin : g_digit
      bcd_digit_t digit;
      logic       wrap;

      assign digit    = value[4*i +: 4];
      assign wrap     = carry[i] && (digit == 4'd9);
      assign carry[i+1] = wrap;
      assign result[4*i +: 4] = wrap ? 4'd0 : (digit + {3'b000, carry[i]});
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/collision_score_counter.sv
// +------------------------------------------------------------------+
// | collision_score_counter: one hit per frame, frame cooldown, BCD  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module collision_score_counter
  import game_pkg::*;
#(
  parameter int          COOLDOWN_FRAMES = 30,
  parameter logic [31:0] FRAME_X0        = 32'd0,
  parameter logic [31:0] FRAME_Y0        = 32'd0
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        clear,
  input  logic        collision,
  input  logic [31:0] pxl_x,
  input  logic [31:0] pxl_y,
  output logic [15:0] score_bcd,
  output logic        hit_pulse,
  output logic        armed,
  output logic        saturated
);

  localparam int CNT_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [15:0]      score_next, score_inc;
  logic             hit_next, sat_next, inc_carry;
  logic             match, match_d, sof;

  // Edge-detect the origin so a stalled (0,0) still yields one SOF per frame
  assign match = (pxl_x == FRAME_X0) && (pxl_y == FRAME_Y0);
  assign sof   = match && !match_d;
  assign armed = (state == ARMED);

  bcd_incrementer u_inc (
    .value     (score_bcd),
    .result    (score_inc),
    .carry_out (inc_carry)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= ARMED;
      cnt       <= '0;
      match_d   <= 1'b0;
      score_bcd <= 16'h0000;
      hit_pulse <= 1'b0;
      saturated <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      match_d   <= match;
      score_bcd <= score_next;
      hit_pulse <= hit_next;
      saturated <= sat_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    score_next = score_bcd;
    hit_next   = 1'b0;
    sat_next   = (score_bcd == BCD_MAX);

    if (clear) begin
      state_next = ARMED;
      cnt_next   = '0;
      score_next = 16'h0000;
      sat_next   = 1'b0;
    end else begin
      case (state)
        ARMED: begin
          if (collision) begin
            hit_next   = 1'b1;
            state_next = HIT;
            // A carry out of the top digit means 9999 -> hold the score
            if (!inc_carry) score_next = score_inc;
          end
        end
        HIT: begin
          if (sof) begin
            if (COOLDOWN_FRAMES == 0) begin
              state_next = ARMED;
            end else begin
              cnt_next   = CNT_LOAD;
              state_next = COOLDOWN;
            end
          end
        end
        COOLDOWN: begin
          if (sof) begin
            if (cnt == CNT_ONE) begin
              state_next = ARMED;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt - CNT_ONE;
            end
          end
        end
        default: begin
          state_next = ARMED;
          cnt_next   = '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_collision_score_counter.sv
// +------------------------------------------------------------------+
// | tb_collision_score_counter: random + directed bench, two configs |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_collision_score_counter;

  localparam int CF_A = 6;
  localparam int CF_B = 0;
  localparam int SCR_W = 8;
  localparam int SCR_H = 3;

  logic        clk = 1'b0;
  logic        resetN;
  logic        clear;
  logic        collision;
  logic [31:0] pxl_x;
  logic [31:0] pxl_y;

  logic [15:0] score_o [2];
  logic        hit_o   [2];
  logic        armed_o [2];
  logic        sat_o   [2];

  always #5 clk = ~clk;

  collision_score_counter #(.COOLDOWN_FRAMES(CF_A), .FRAME_X0(32'd0), .FRAME_Y0(32'd0)) dut_a (
    .clk(clk), .resetN(resetN), .clear(clear), .collision(collision),
    .pxl_x(pxl_x), .pxl_y(pxl_y),
    .score_bcd(score_o[0]), .hit_pulse(hit_o[0]), .armed(armed_o[0]), .saturated(sat_o[0])
  );

  collision_score_counter #(.COOLDOWN_FRAMES(CF_B), .FRAME_X0(32'd0), .FRAME_Y0(32'd0)) dut_b (
    .clk(clk), .resetN(resetN), .clear(clear), .collision(collision),
    .pxl_x(pxl_x), .pxl_y(pxl_y),
    .score_bcd(score_o[1]), .hit_pulse(hit_o[1]), .armed(armed_o[1]), .saturated(sat_o[1])
  );

  // Reference model: decimal score, "in the hit's frame" flag, frames still to wait
  int cf_tab [2] = '{CF_A, CF_B};
  int m_score [2];
  bit m_inhit [2];
  int m_wait  [2];
  bit m_hit   [2];
  bit m_sat   [2];
  bit m_prev_origin;

  int n_vec = 0;
  int n_err = 0;

  int scan_x = 0;
  int scan_y = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_prev_origin = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_score[i] = 0;
      m_inhit[i] = 1'b0;
      m_wait[i]  = 0;
      m_hit[i]   = 1'b0;
      m_sat[i]   = 1'b0;
    end
  endtask

  task automatic model_clock(input bit coll, input bit clr, input logic [31:0] x, input logic [31:0] y);
    bit origin, new_frame, sat_n;
    origin        = (x == 0) && (y == 0);
    new_frame     = origin && !m_prev_origin;
    m_prev_origin = origin;
    for (int i = 0; i < 2; i++) begin
      sat_n    = !clr && (m_score[i] == 9999);
      m_hit[i] = 1'b0;
      if (clr) begin
        m_score[i] = 0;
        m_inhit[i] = 1'b0;
        m_wait[i]  = 0;
      end else if (!m_inhit[i] && m_wait[i] == 0 && coll) begin
        m_hit[i]   = 1'b1;
        m_inhit[i] = 1'b1;
        if (m_score[i] < 9999) m_score[i] = m_score[i] + 1;
      end else if (new_frame) begin
        if (m_inhit[i]) begin
          m_inhit[i] = 1'b0;
          m_wait[i]  = cf_tab[i];
        end else if (m_wait[i] > 0) begin
          m_wait[i] = m_wait[i] - 1;
        end
      end
      m_sat[i] = sat_n;
    end
  endtask

  task automatic compare_all();
    chk("a_score", score_o[0], to_bcd(m_score[0]));
    chk("a_hit",   16'(hit_o[0]),   16'(m_hit[0]));
    chk("a_armed", 16'(armed_o[0]), 16'(!m_inhit[0] && m_wait[0] == 0));
    chk("a_sat",   16'(sat_o[0]),   16'(m_sat[0]));
    chk("b_score", score_o[1], to_bcd(m_score[1]));
    chk("b_hit",   16'(hit_o[1]),   16'(m_hit[1]));
    chk("b_armed", 16'(armed_o[1]), 16'(!m_inhit[1] && m_wait[1] == 0));
    chk("b_sat",   16'(sat_o[1]),   16'(m_sat[1]));
  endtask

  task automatic step(input bit coll, input bit clr, input logic [31:0] x, input logic [31:0] y);
    collision = coll;
    clear     = clr;
    pxl_x     = x;
    pxl_y     = y;
    @(posedge clk);
    model_clock(coll, clr, x, y);
    #1;
    compare_all();
  endtask

  task automatic scan_step(input bit coll, input bit clr);
    step(coll, clr, 32'(scan_x), 32'(scan_y));
    if ($urandom_range(0, 9) != 0) begin
      scan_x++;
      if (scan_x == SCR_W) begin
        scan_x = 0;
        scan_y = (scan_y + 1) % SCR_H;
      end
    end
  endtask

  initial begin
    int guard;
    resetN    = 1'b0;
    clear     = 1'b0;
    collision = 1'b0;
    pxl_x     = 32'd5;
    pxl_y     = 32'd5;
    model_reset();
    #2;
    compare_all();
    @(negedge clk);
    resetN = 1'b1;

    // Single collision off the origin, then a held collision within one frame
    step(1'b1, 1'b0, 32'd100, 32'd50);
    chk("t1_score", score_o[0], 16'h0001);
    step(1'b0, 1'b0, 32'd101, 32'd50);
    for (int k = 0; k < 200; k++) step(1'b1, 1'b0, 32'(102 + k), 32'd50);
    chk("t2_score", score_o[0], 16'h0001);

    // Randomized traffic with frame scanning, stalls and rare clears
    for (int k = 0; k < 3000; k++)
      scan_step($urandom_range(0, 4) == 0, $urandom_range(0, 299) == 0);

    // clear wins over a simultaneous collision
    step(1'b0, 1'b1, 32'd3, 32'd1);
    step(1'b1, 1'b1, 32'd4, 32'd1);
    chk("t5_score", score_o[0], 16'h0000);
    chk("t5_armed", 16'(armed_o[0]), 16'h0001);

    // Asynchronous reset while the long-cooldown instance has 5 frames left
    guard = 0;
    while (!m_inhit[0] && guard < 100) begin
      scan_step(1'b1, 1'b0);
      guard++;
    end
    while (m_wait[0] != 5 && guard < 2000) begin
      scan_step(1'b0, 1'b0);
      guard++;
    end
    chk("t6_reach_cnt5", 16'(m_wait[0]), 16'd5);
    resetN = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    resetN = 1'b1;
    step(1'b1, 1'b0, 32'd100, 32'd50);
    chk("t6_score", score_o[0], 16'h0001);

    // Drive the zero-cooldown instance to 9999 and beyond with 2-pixel frames
    step(1'b0, 1'b1, 32'd1, 32'd0);
    guard = 0;
    while (m_score[1] < 9999 && guard < 40000) begin
      step(1'b1, 1'b0, 32'(guard % 2), 32'd0);
      guard++;
    end
    chk("t4_reach_max", to_bcd(m_score[1]), 16'h9999);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0, 32'(guard % 2), 32'd0);
      guard++;
    end
    chk("t4_sat", 16'(sat_o[1]), 16'h0001);
    chk("t4_hold", score_o[1], 16'h9999);
    step(1'b0, 1'b1, 32'd1, 32'd0);
    chk("t4_clear_sat", 16'(sat_o[1]), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
